// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned DefAddrW  = 20;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefRdWait = 2;
  localparam int unsigned DefWrWait = 2;
  // Wait counts are at most 15, so a 4-bit counter covers every legal setting
  localparam int unsigned CntW      = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;

  typedef enum logic {GNT_CPU, GNT_LDR} grant_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way grant selection between the CPU and loader ports.
// Build option: define SRAM_ARB_CPU_PRIO_EN for fixed CPU priority; the default
// is round-robin against the last completed grant.
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,      // synchronous, active-low
  input  logic cpu_req_i,
  input  logic ldr_req_i,
  input  logic done_i,      // high during the DONE cycle of a transaction
  input  logic done_ldr_i,  // port that owns that transaction (1 = loader)
  output logic gnt_ldr_o    // selected port when any request is high (1 = loader)
);

  grant_t last_q;

  // Remember who finished last; reset favours the CPU on the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= GNT_LDR;
    end else if (done_i) begin
      last_q <= grant_t'(done_ldr_i);
    end
  end

`ifdef SRAM_ARB_CPU_PRIO_EN
  // Fixed priority: the loader only wins when the CPU is quiet
  always_comb begin
    gnt_ldr_o = 1'b0;
    if (!cpu_req_i && ldr_req_i) begin
      gnt_ldr_o = 1'b1;
    end
  end
`else
  // Round-robin: on a tie hand the bus to whoever did not have it last
  always_comb begin
    gnt_ldr_o = 1'b0;
    if (cpu_req_i && ldr_req_i) begin
      gnt_ldr_o = (last_q == GNT_CPU);
    end else if (ldr_req_i) begin
      gnt_ldr_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the CPU and a loader/DMA port.
// Accesses run IDLE -> SETUP -> ACCESS (wait states) -> DONE; every SRAM pin is
// driven from a register. Build option SRAM_ARB_CPU_PRIO_EN selects fixed CPU
// priority inside sram_rr_arbiter.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned RD_WAIT = DefRdWait,
  parameter int unsigned WR_WAIT = DefWrWait
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  localparam logic [CntW-1:0] RdLoad = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_WAIT - 1);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  grant_t            grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              wen_q, wen_d;
  logic              drv_q, drv_d;
  logic              cpu_ack_q, ldr_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;

  logic              gnt_ldr;
  logic              active;
  logic              rd_fire;

  sram_rr_arbiter u_rr (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .cpu_req_i  (cpu_req),
    .ldr_req_i  (ldr_req),
    .done_i     (state_q == DONE),
    .done_ldr_i (grant_q == GNT_LDR),
    .gnt_ldr_o  (gnt_ldr)
  );

  // Next-state, transaction latch and next values of the registered pins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          grant_d = grant_t'(gnt_ldr);
          if (gnt_ldr) begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = we_q ? WrLoad : RdLoad;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pins follow the state being entered so they are valid for that whole cycle
    active = (state_d == SETUP) || (state_d == ACCESS);
    ce_d   = !active;
    oe_d   = !(active && !we_d);
    wen_d  = !((state_d == ACCESS) && we_d);
    drv_d  = active && we_d;
  end

  // Read data is captured on the edge that ends the last ACCESS cycle
  assign rd_fire = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

  // State, transaction and pin registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= GNT_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      wen_q     <= 1'b1;
      drv_q     <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      wen_q     <= wen_d;
      drv_q     <= drv_d;
      cpu_ack_q <= (state_d == DONE) && (grant_q == GNT_CPU);
      ldr_ack_q <= (state_d == DONE) && (grant_q == GNT_LDR);
    end
  end

  // Per-port read data holds until that port's next read completes
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (rd_fire) begin
      if (grant_q == GNT_LDR) begin
        ldr_rdata_q <= Data;
      end else begin
        cpu_rdata_q <= Data;
      end
    end
  end

  assign CE        = ce_q;
  assign UB        = ce_q;
  assign LB        = ce_q;
  assign OE        = oe_q;
  assign WE        = wen_q;
  assign ADDR      = addr_q;
  assign Data      = drv_q ? wdata_q : 'z;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural async SRAM model.
// The data bus is pulled high, so a released bus reads back as 16'hFFFF.
module tb_sram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 2;
  localparam int unsigned WW = 2;
  localparam logic [15:0] Floating = 16'hFFFF;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata;
  logic          cpu_ack, ldr_ack;
  logic          CE, UB, LB, OE, WE;
  logic [AW-1:0] ADDR;
  tri1  [DW-1:0] data_bus;

  logic [DW-1:0] mem [0:255];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          mon_en   = 1'b0;

  always #5 Clk = ~Clk;

  sram_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_WAIT (RW),
    .WR_WAIT (WW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_rdata (ldr_rdata),
    .ldr_ack   (ldr_ack),
    .CE        (CE),
    .UB        (UB),
    .LB        (LB),
    .OE        (OE),
    .WE        (WE),
    .ADDR      (ADDR),
    .Data      (data_bus)
  );

  // SRAM model: drives on a read strobe, stores while WE is low
  assign data_bus = (!CE && !OE && WE) ? mem[ADDR[7:0]] : 'z;

  always @(posedge Clk) begin
    if (!CE && !WE) mem[ADDR[7:0]] <= data_bus;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Continuous bus-safety checks
  always @(negedge Clk) begin
    if (mon_en) begin
      check_eq("we_oe_excl", {31'd0, (WE | OE)}, 32'd1);
      check_eq("ce_high_idle", {30'd0, (CE ? {OE, WE} : 2'b11)}, 32'd3);
    end
  end

  // One complete transaction on one port with bounded wait for the ack
  task automatic run_xfer(input bit is_ldr, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                          input string tag);
    int n = 0;
    bit got = 1'b0;
    bit other = 1'b0;
    if (is_ldr) begin
      ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end
    while (!got && n < 20) begin
      tick();
      n++;
      if (is_ldr ? ldr_ack : cpu_ack) got = 1'b1;
      if (is_ldr ? cpu_ack : ldr_ack) other = 1'b1;
    end
    check_eq({tag, "_latency"}, n, 2 + (we ? WW : RW));
    check_eq({tag, "_other_ack"}, {31'd0, other}, 32'd0);
    if (!we) check_eq({tag, "_rdata"}, is_ldr ? ldr_rdata : cpu_rdata, exp_rd);
    tick();
    if (is_ldr) ldr_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          n_acks;
    bit          ack_port [4];
    int          ack_cyc  [4];
    bit          exp_port [4];
    int          cpu_cyc, ldr_cyc;
    bit          drop_cpu;
    bit          stray;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;

    // Reset state
    Reset = 1'b0;
    tick();
    tick();
    check_eq("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
    check_eq("rst_addr", ADDR, 32'd0);
    check_eq("rst_data", data_bus, Floating);
    check_eq("rst_acks", {30'd0, cpu_ack, ldr_ack}, 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_ldr_rdata", ldr_rdata, 32'd0);
    Reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // CPU read of 0x00010, cycle by cycle
    cpu_we = 0; cpu_addr = 20'h00010; cpu_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("rd_oe_c%0d", k), OE, (k <= 3) ? 32'd0 : 32'd1);
      check_eq($sformatf("rd_ce_c%0d", k), CE, (k <= 3) ? 32'd0 : 32'd1);
      check_eq($sformatf("rd_ack_c%0d", k), cpu_ack, (k == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("rd_ldr_ack_c%0d", k), ldr_ack, 32'd0);
    end
    check_eq("rd_rdata", cpu_rdata, 32'h1234);
    tick();
    cpu_req = 1'b0;

    // Loader write of 0xBEEF to 0x00020, cycle by cycle
    ldr_we = 1'b1; ldr_addr = 20'h00020; ldr_wdata = 16'hBEEF; ldr_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("wr_we_c%0d", k), WE, (k == 2 || k == 3) ? 32'd0 : 32'd1);
      check_eq($sformatf("wr_oe_c%0d", k), OE, 32'd1);
      check_eq($sformatf("wr_data_c%0d", k), data_bus, (k <= 3) ? 32'hBEEF : Floating);
      check_eq($sformatf("wr_ack_c%0d", k), ldr_ack, (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
    ldr_req = 1'b0;

    run_xfer(1'b0, 1'b0, 20'h00020, 16'h0000, 16'hBEEF, "cpu_rd_back");

    // Both ports request continuously after a fresh reset
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    cpu_we = 0; cpu_addr = 20'h00010; cpu_req = 1'b1;
    ldr_we = 0; ldr_addr = 20'h00020; ldr_req = 1'b1;
`ifdef SRAM_ARB_CPU_PRIO_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    cyc = 0;
    n_acks = 0;
    while (n_acks < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (cpu_ack || ldr_ack) begin
        ack_port[n_acks] = ldr_ack;
        ack_cyc[n_acks]  = cyc;
        if (ldr_ack) check_eq("rr_ldr_rdata", ldr_rdata, 32'hBEEF);
        else         check_eq("rr_cpu_rdata", cpu_rdata, 32'h1234);
        n_acks++;
      end
    end
    check_eq("rr_ack_count", n_acks, 32'd4);
    for (int i = 0; i < n_acks; i++) begin
      check_eq($sformatf("rr_port_%0d", i), {31'd0, ack_port[i]}, {31'd0, exp_port[i]});
      check_eq($sformatf("rr_cycle_%0d", i), ack_cyc[i], 4 + 5 * i);
    end
    tick();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    tick();

    // Reset in the first ACCESS cycle of a CPU write
    cpu_we = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 16'h5555; cpu_req = 1'b1;
    tick();
    check_eq("abort_setup_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h03);
    tick();
    check_eq("abort_access_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h02);
    Reset = 1'b0;
    cpu_req = 1'b0;
    tick();
    check_eq("abort_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
    check_eq("abort_data", data_bus, Floating);
    check_eq("abort_ack", cpu_ack, 32'd0);
    Reset = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cpu_ack || ldr_ack) stray = 1'b1;
    end
    check_eq("abort_no_late_ack", {31'd0, stray}, 32'd0);
    run_xfer(1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, "post_abort_rd");

    // Loader request arriving while the CPU is in ACCESS
    cpu_we = 0; cpu_addr = 20'h00010; cpu_req = 1'b1;
    ldr_we = 0; ldr_addr = 20'h00020;
    cyc = 0; cpu_cyc = -1; ldr_cyc = -1; drop_cpu = 1'b0;
    while (ldr_cyc < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (drop_cpu) begin
        cpu_req = 1'b0;
        drop_cpu = 1'b0;
      end
      if (cyc == 2) ldr_req = 1'b1;
      if (cpu_ack) begin
        cpu_cyc = cyc;
        drop_cpu = 1'b1;
      end
      if (ldr_ack) ldr_cyc = cyc;
    end
    check_eq("late_cpu_ack_cycle", cpu_cyc, 32'd4);
    check_eq("late_ldr_ack_cycle", ldr_cyc, 32'd9);
    check_eq("late_ldr_rdata", ldr_rdata, 32'hBEEF);
    tick();
    ldr_req = 1'b0;
    tick();
    tick();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
